// File: rtl/regbank_write_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regbank_write_demux_pkg
// Purpose  : Shared constants and FSM state encoding for the register-bank
//            write side (regbank_write_demux and its decoder / interface).
// Contents : REGBANK_NREGS / REGBANK_DW / REGBANK_AW sizes, state_t enum.
// Revision : 1.0 - initial release
// ============================================================================
package regbank_write_demux_pkg;

  localparam int REGBANK_NREGS = 8;
  localparam int REGBANK_DW    = 8;
  localparam int REGBANK_AW    = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage : regbank_write_demux_pkg
`default_nettype wire

// File: rtl/regbank_write_demux_if.sv
`default_nettype none
// ============================================================================
// Module   : regbank_write_demux_if
// Purpose  : Bundles the write handshake, clear control, debug observe and
//            read port of the register bank write side.
// Modports : slave  - the register bank (drives ready/busy/done/regs/rd_data)
//            master - the requester (drives valid/addr/data/clr_req/rd_addr)
// Revision : 1.0 - initial release
// ============================================================================
interface regbank_write_demux_if;
  import regbank_write_demux_pkg::*;

  logic                                wr_valid;
  logic                                wr_ready;
  logic [REGBANK_AW-1:0]               wr_addr;
  logic [REGBANK_DW-1:0]               wr_data;
  logic                                clr_req;
  logic                                clr_busy;
  logic [REGBANK_NREGS-1:0]            wr_en_onehot;
  logic                                wr_done;
  logic [REGBANK_NREGS*REGBANK_DW-1:0] regs_flat;
  logic [REGBANK_AW-1:0]               rd_addr;
  logic [REGBANK_DW-1:0]               rd_data;

  modport slave (
    input  wr_valid, wr_addr, wr_data, clr_req, rd_addr,
    output wr_ready, clr_busy, wr_en_onehot, wr_done, regs_flat, rd_data
  );

  modport master (
    output wr_valid, wr_addr, wr_data, clr_req, rd_addr,
    input  wr_ready, clr_busy, wr_en_onehot, wr_done, regs_flat, rd_data
  );

endinterface : regbank_write_demux_if
`default_nettype wire

// File: rtl/regbank_write_demux_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : regbank_addr_decode
// Purpose  : Combinational 3-to-8 one-hot decoder with enable.
// Ports    : i_addr   - register index
//            i_en     - when low the output is all zeros
//            o_onehot - one-hot select, bit i_addr set when enabled
// Revision : 1.0 - initial release
// ============================================================================
module regbank_addr_decode
  import regbank_write_demux_pkg::*;
(
  input  wire logic [REGBANK_AW-1:0]    i_addr,
  input  wire logic                     i_en,
  output logic      [REGBANK_NREGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_addr] = 1'b1;
    end
  end

endmodule : regbank_addr_decode
`default_nettype wire

// File: rtl/regbank_write_demux.sv
`default_nettype none
// ============================================================================
// Module   : regbank_write_demux
// Purpose  : Write side of the 8x8-bit CPU register bank. Writes arrive on a
//            valid/ready handshake, are staged for one cycle and committed to
//            the addressed register. A clear sequencer zeroes one register
//            per cycle; a combinational read port returns reg[rd_addr].
// Ports    : clk   - system clock, rising edge
//            rst_n - synchronous active-low reset
//            bus   - regbank_write_demux_if.slave (handshake, clear, observe,
//                    read port, flattened register outputs)
// Options  : REGBANK_WRITE_BYPASS_EN - read port forwards a staged write and
//            reports registers already/currently being cleared as zero.
// Revision : 1.0 - initial release
// ============================================================================
module regbank_write_demux
  import regbank_write_demux_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            rst_n,
  regbank_write_demux_if.slave bus
);

  localparam int NREGS = REGBANK_NREGS;
  localparam int DW    = REGBANK_DW;
  localparam int AW    = REGBANK_AW;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AW-1:0]        r_cnt;
  logic                 r_stg_valid;
  logic [AW-1:0]        r_stg_addr;
  logic [DW-1:0]        r_stg_data;
  logic [NREGS-1:0]     r_wr_en_onehot;
  logic                 r_wr_done;
  logic                 r_clr_busy;
  logic [DW-1:0]        r_regs [NREGS];

  logic                 w_ready;
  logic                 w_accept;
  logic [NREGS-1:0]     w_stg_onehot;
  logic [NREGS-1:0]     w_clr_onehot;
  logic [DW-1:0]        w_rd_data;
  logic [NREGS*DW-1:0]  w_regs_flat;

  // clr_req outranks a simultaneous write so the clear never races a new one.
  assign w_ready  = (r_state == ST_IDLE) && !bus.clr_req;
  assign w_accept = bus.wr_valid && w_ready;

  // Decode of the write being accepted; registered into wr_en_onehot.
  regbank_addr_decode u_stg_decode (
    .i_addr   (bus.wr_addr),
    .i_en     (w_accept),
    .o_onehot (w_stg_onehot)
  );

  // Decode of the register zeroed by the clear sequencer this cycle.
  regbank_addr_decode u_clr_decode (
    .i_addr   (r_cnt),
    .i_en     (r_state == ST_CLEAR),
    .o_onehot (w_clr_onehot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.clr_req) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (r_cnt == AW'(NREGS - 1)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_stg_valid    <= 1'b0;
      r_stg_addr     <= '0;
      r_stg_data     <= '0;
      r_wr_en_onehot <= '0;
      r_wr_done      <= 1'b0;
      r_clr_busy     <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_stg_valid    <= w_accept;
      r_wr_en_onehot <= w_stg_onehot;
      r_wr_done      <= r_stg_valid;
      r_clr_busy     <= (w_state_nxt == ST_CLEAR);
      if (w_accept) begin
        r_stg_addr <= bus.wr_addr;
        r_stg_data <= bus.wr_data;
      end
      // Natural AW-bit wrap brings the counter back to 0 after reg 7.
      if (r_state == ST_CLEAR) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      // A staged write and a clear step never share an edge: nothing is
      // accepted on the edge entering CLEAR or while in it.
      if (r_stg_valid) begin
        r_regs[r_stg_addr] <= r_stg_data;
      end
      for (int i = 0; i < NREGS; i++) begin
        if (w_clr_onehot[i]) begin
          r_regs[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_rd_data = r_regs[bus.rd_addr];
`ifdef REGBANK_WRITE_BYPASS_EN
    if (r_stg_valid && (r_stg_addr == bus.rd_addr)) begin
      w_rd_data = r_stg_data;
    end
    if ((r_state == ST_CLEAR) && (bus.rd_addr <= r_cnt)) begin
      w_rd_data = '0;
    end
`endif
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
    assign w_regs_flat[gi*DW +: DW] = r_regs[gi];
  end

  assign bus.wr_ready     = w_ready;
  assign bus.clr_busy     = r_clr_busy;
  assign bus.wr_en_onehot = r_wr_en_onehot;
  assign bus.wr_done      = r_wr_done;
  assign bus.regs_flat    = w_regs_flat;
  assign bus.rd_data      = w_rd_data;

endmodule : regbank_write_demux
`default_nettype wire

// File: tb/tb_regbank_write_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_write_demux
// Purpose  : Self-checking bench for regbank_write_demux. Directed scenarios
//            followed by random traffic; a behavioural model of the register
//            bank predicts every output, and accepted writes are queued and
//            matched against wr_done pulses by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_write_demux;
  import regbank_write_demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regbank_write_demux_if bus ();

  regbank_write_demux dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  // Behavioural model of the bank
  logic [7:0] m_regs [8];
  bit         m_busy;
  int         m_cnt;
  bit         m_stg_v;
  logic [2:0] m_stg_a;
  logic [7:0] m_stg_d;
  bit         m_done;
  bit         m_init = 1'b0;
  wr_t        exp_q [$];

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the rules to the inputs the DUT just sampled at this edge.
  task automatic model_step();
    bit  ready;
    wr_t w;
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_busy  = 1'b0;
      m_cnt   = 0;
      m_stg_v = 1'b0;
      m_done  = 1'b0;
      exp_q.delete();
      m_init  = 1'b1;
      return;
    end
    if (!m_init) return;
    ready  = !m_busy && !bus.clr_req;
    m_done = m_stg_v;
    if (m_stg_v) m_regs[m_stg_a] = m_stg_d;
    if (m_busy) begin
      m_regs[m_cnt] = 8'h00;
      if (m_cnt == 7) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end else if (bus.clr_req) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end
    m_stg_v = ready && bus.wr_valid;
    if (m_stg_v) begin
      m_stg_a = bus.wr_addr;
      m_stg_d = bus.wr_data;
      w.a = bus.wr_addr;
      w.d = bus.wr_data;
      exp_q.push_back(w);
    end
  endtask

  function automatic logic [7:0] model_rd(logic [2:0] ra);
    logic [7:0] v;
    v = m_regs[ra];
`ifdef REGBANK_WRITE_BYPASS_EN
    if (m_stg_v && m_stg_a == ra) v = m_stg_d;
    else if (m_busy && int'(ra) <= m_cnt) v = 8'h00;
`endif
    return v;
  endfunction

  // One cycle of stimulus: drive at negedge, let the model see the edge.
  task automatic cyc(bit v, logic [2:0] a, logic [7:0] d, bit clr, bit rn, logic [2:0] rd);
    @(negedge clk);
    bus.wr_valid = v;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.clr_req  = clr;
    bus.rd_addr  = rd;
    rst_n        = rn;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle(int n, logic [2:0] rd);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, rd);
  endtask

  // Monitor: compares every cycle, and pops the scoreboard on wr_done.
  initial begin : monitor
    logic [63:0] exp_flat;
    logic [7:0]  onehot;
    wr_t         w;
    forever begin
      @(posedge clk);
      #2;
      if (m_init) begin
        foreach (m_regs[i]) exp_flat[i*8 +: 8] = m_regs[i];
        onehot = m_stg_v ? (8'h01 << m_stg_a) : 8'h00;
        check("wr_ready",     bus.wr_ready,     !m_busy && !bus.clr_req);
        check("clr_busy",     bus.clr_busy,     m_busy);
        check("wr_done",      bus.wr_done,      m_done);
        check("wr_en_onehot", bus.wr_en_onehot, onehot);
        check("regs_flat",    bus.regs_flat,    exp_flat);
        check("rd_data",      bus.rd_data,      model_rd(bus.rd_addr));
        if (bus.wr_done === 1'b1) begin
          check("done_has_pending_write", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("committed_byte", bus.regs_flat[w.a*8 +: 8], w.d);
          end
        end
      end
    end
  end

  initial begin : driver
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.clr_req  = 1'b0;
    bus.rd_addr  = '0;
    rst_n        = 1'b0;

    for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0);

    // Single write, then back-to-back writes to one register
    cyc(1'b1, 3'd3, 8'hA5, 1'b0, 1'b1, 3'd3);
    idle(2, 3'd3);
    cyc(1'b1, 3'd5, 8'h11, 1'b0, 1'b1, 3'd5);
    cyc(1'b1, 3'd5, 8'h22, 1'b0, 1'b1, 3'd5);
    idle(2, 3'd5);

    // Fill with 0xFF, then a clear pulse while sweeping the read port
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 8'hFF, 1'b0, 1'b1, 3'd0);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'(i));

    // Write colliding with clr_req, and clr_req repeated during CLEAR
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 8'h5A, 1'b0, 1'b1, 3'd2);
    cyc(1'b1, 3'd2, 8'h77, 1'b1, 1'b1, 3'd2);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd2);
    idle(9, 3'd2);

    // Reset in the middle of a clear, then a fresh write
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 8'(8'h10 + i), 1'b0, 1'b1, 3'd4);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd4);
    idle(4, 3'd4);
    cyc(1'b1, 3'd1, 8'hEE, 1'b0, 1'b0, 3'd4);
    cyc(1'b1, 3'd4, 8'h5A, 1'b0, 1'b1, 3'd4);
    idle(3, 3'd4);

    // Read of a staged write (forwarded only with the bypass option)
    cyc(1'b1, 3'd6, 8'h3C, 1'b0, 1'b1, 3'd6);
    idle(2, 3'd6);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 99) < 60),
          3'($urandom_range(0, 7)),
          8'($urandom),
          ($urandom_range(0, 99) < 4),
          !($urandom_range(0, 199) == 0),
          3'($urandom_range(0, 7)));
    end

    idle(12, 3'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regbank_write_demux
`default_nettype wire
